// File: rtl/softex_tcdm_pkg.sv
// Shared types and helpers for the SoftEx TCDM responder and its banks.
package softex_tcdm_pkg;

    localparam int unsigned TCDM_ID_W_MAX = 32;
    localparam logic [63:0] OOR_PATTERN   = 64'hDEAD_BEEF_DEAD_BEEF;

    // Ids are carried at the widest supported width and narrowed at the ports.
    typedef struct packed {
        logic [31:0]              add;
        logic                     wen;
        logic [7:0]               be;
        logic [63:0]              data;
        logic [TCDM_ID_W_MAX-1:0] id;
    } tcdm_req_t;

    typedef struct packed {
        logic [63:0]              r_data;
        logic [TCDM_ID_W_MAX-1:0] r_id;
        logic                     r_valid;
    } tcdm_rsp_t;

    function automatic int unsigned bank_of(input logic [28:0] word, input int unsigned n_banks);
        logic [31:0] w;
        w = {3'b000, word};
        return w % n_banks;
    endfunction

endpackage

// File: rtl/softex_tcdm_bank.sv
// Single-port, byte-enabled synchronous SRAM bank; read data is registered.
module softex_tcdm_bank #(
    parameter int unsigned ROWS  = 256,
    parameter int unsigned ROW_W = 8
) (
    input  logic             clk_i,
    input  logic             en,
    input  logic             we,
    input  logic [ROW_W-1:0] row,
    input  logic [7:0]       be,
    input  logic [63:0]      wdata,
    output logic [63:0]      rdata
);

    logic [63:0] mem [ROWS];

    // Contents are deliberately left unreset.
    always_ff @(posedge clk_i) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < 8; i++) begin
                    if (be[i]) mem[row][8*i +: 8] <= wdata[8*i +: 8];
                end
            end else begin
                rdata <= mem[row];
            end
        end
    end

endmodule

// File: rtl/softex_tcdm_responder.sv
// Multi-port banked TCDM slave memory with fixed read latency and per-port backpressure.
// Define SOFTEX_TCDM_STALL_EN to add LFSR-driven random grant denial per port.
module softex_tcdm_responder
    import softex_tcdm_pkg::*;
#(
    parameter int unsigned MP        = 4,
    parameter int unsigned N_WORDS   = 1024,
    parameter int unsigned LATENCY   = 1,
    parameter int unsigned ID_W      = 8,
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [MP-1:0]    tcdm_req_i,
    output logic [MP-1:0]    tcdm_gnt_o,
    input  logic [MP*32-1:0] tcdm_add_i,
    input  logic [MP-1:0]    tcdm_wen_i,
    input  logic [MP*8-1:0]  tcdm_be_i,
    input  logic [MP*64-1:0] tcdm_data_i,
    input  logic [MP*ID_W-1:0] tcdm_id_i,
    input  logic [MP-1:0]    tcdm_r_ready_i,
    output logic [MP*64-1:0] tcdm_r_data_o,
    output logic [MP-1:0]    tcdm_r_valid_o,
    output logic [MP*ID_W-1:0] tcdm_r_id_o,
    output logic             err_o
);

    localparam int unsigned ROWS   = N_WORDS / MP;
    localparam int unsigned ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned BANK_W = (MP > 1) ? $clog2(MP) : 1;
    localparam logic [31:0] SPAN   = 32'(8 * N_WORDS);

    // fresh: data still sits in the bank's read register and must be captured this cycle.
    typedef struct packed {
        logic              valid;
        logic              fresh;
        logic [BANK_W-1:0] bank;
        logic [ID_W-1:0]   id;
        logic [63:0]       data;
    } stage_t;

    tcdm_req_t         req      [MP];
    tcdm_rsp_t         rsp      [MP];
    logic [31:0]       req_off  [MP];
    logic [BANK_W-1:0] req_bank [MP];
    logic [ROW_W-1:0]  req_row  [MP];
    logic [MP-1:0]     req_oor;
    logic [MP-1:0]     stall;
    logic [MP-1:0]     hold;
    logic [MP-1:0]     elig;
    logic [MP-1:0]     gnt;

    logic [MP-1:0]     bank_en;
    logic              bank_we    [MP];
    logic [ROW_W-1:0]  bank_row   [MP];
    logic [7:0]        bank_be    [MP];
    logic [63:0]       bank_wdata [MP];
    logic [63:0]       bank_rdata [MP];

    stage_t            pipe  [MP][LATENCY];
    stage_t            aged  [MP][LATENCY];
    stage_t            entry [MP];
    logic              err_sticky;
    logic              unused_id_bits;

    always_comb begin
        for (int p = 0; p < MP; p++) begin
            req[p].add  = tcdm_add_i[32*p +: 32];
            req[p].wen  = tcdm_wen_i[p];
            req[p].be   = tcdm_be_i[8*p +: 8];
            req[p].data = tcdm_data_i[64*p +: 64];
            req[p].id   = TCDM_ID_W_MAX'(tcdm_id_i[ID_W*p +: ID_W]);
            req_off[p]  = req[p].add - BASE_ADDR;
            req_oor[p]  = req_off[p] >= SPAN;
            req_bank[p] = BANK_W'(bank_of(req_off[p][31:3], MP));
            req_row[p]  = ROW_W'(32'(req_off[p][31:3]) / MP);
        end
    end

    always_comb begin
        hold = '0;
        for (int p = 0; p < MP; p++) begin
            hold[p] = pipe[p][LATENCY-1].valid & ~tcdm_r_ready_i[p];
        end
    end

`ifdef SOFTEX_TCDM_STALL_EN
    logic [15:0] lfsr [MP];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int p = 0; p < MP; p++) lfsr[p] <= 16'hACE1 ^ 16'(p);
        end else begin
            for (int p = 0; p < MP; p++) begin
                lfsr[p] <= {lfsr[p][14:0], lfsr[p][15] ^ lfsr[p][13] ^ lfsr[p][12] ^ lfsr[p][10]};
            end
        end
    end

    always_comb begin
        stall = '0;
        for (int p = 0; p < MP; p++) begin
            stall[p] = hold[p] | (lfsr[p][1:0] == 2'b11);
        end
    end
`else
    assign stall = hold;
`endif

    assign elig = tcdm_req_i & ~stall;

    // Out-of-range requests touch no bank, so they never block or get blocked.
    always_comb begin
        gnt = '0;
        for (int p = 0; p < MP; p++) begin
            gnt[p] = elig[p] & rst_ni;
            for (int q = 0; q < p; q++) begin
                if (elig[q] && !req_oor[q] && !req_oor[p] && (req_bank[q] == req_bank[p])) begin
                    gnt[p] = 1'b0;
                end
            end
        end
    end

    assign tcdm_gnt_o = gnt;

    always_comb begin
        bank_en = '0;
        for (int b = 0; b < MP; b++) begin
            bank_we[b]    = 1'b0;
            bank_row[b]   = '0;
            bank_be[b]    = '0;
            bank_wdata[b] = '0;
            for (int p = 0; p < MP; p++) begin
                if (gnt[p] && !req_oor[p] && (req_bank[p] == BANK_W'(b))) begin
                    bank_en[b]    = 1'b1;
                    bank_we[b]    = ~req[p].wen;
                    bank_row[b]   = req_row[p];
                    bank_be[b]    = req[p].be;
                    bank_wdata[b] = req[p].data;
                end
            end
        end
    end

    for (genvar b = 0; b < MP; b++) begin : g_bank
        softex_tcdm_bank #(
            .ROWS  (ROWS),
            .ROW_W (ROW_W)
        ) u_bank (
            .clk_i (clk_i),
            .en    (bank_en[b]),
            .we    (bank_we[b]),
            .row   (bank_row[b]),
            .be    (bank_be[b]),
            .wdata (bank_wdata[b]),
            .rdata (bank_rdata[b])
        );
    end

    always_comb begin
        for (int p = 0; p < MP; p++) begin
            entry[p]       = '0;
            entry[p].valid = gnt[p] & req[p].wen;
            entry[p].fresh = gnt[p] & req[p].wen & ~req_oor[p];
            entry[p].bank  = req_bank[p];
            entry[p].id    = req[p].id[ID_W-1:0];
            entry[p].data  = req_oor[p] ? OOR_PATTERN : 64'h0;
            for (int k = 0; k < LATENCY; k++) begin
                aged[p][k]       = pipe[p][k];
                aged[p][k].fresh = 1'b0;
                if (pipe[p][k].fresh) aged[p][k].data = bank_rdata[pipe[p][k].bank];
            end
        end
    end

    // A held output freezes the whole port pipeline; every stage re-captures its data.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int p = 0; p < MP; p++) begin
                for (int k = 0; k < LATENCY; k++) pipe[p][k] <= '0;
            end
        end else begin
            for (int p = 0; p < MP; p++) begin
                if (!hold[p]) begin
                    pipe[p][0] <= entry[p];
                    for (int k = 1; k < LATENCY; k++) pipe[p][k] <= aged[p][k-1];
                end else begin
                    for (int k = 0; k < LATENCY; k++) pipe[p][k] <= aged[p][k];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_sticky <= 1'b0;
        end else if (|(gnt & req_oor)) begin
            err_sticky <= 1'b1;
        end
    end

    assign err_o = err_sticky;

    always_comb begin
        tcdm_r_data_o  = '0;
        tcdm_r_valid_o = '0;
        tcdm_r_id_o    = '0;
        unused_id_bits = 1'b0;
        for (int p = 0; p < MP; p++) begin
            rsp[p].r_valid = pipe[p][LATENCY-1].valid;
            rsp[p].r_data  = aged[p][LATENCY-1].data;
            rsp[p].r_id    = TCDM_ID_W_MAX'(pipe[p][LATENCY-1].id);
            tcdm_r_valid_o[p]           = rsp[p].r_valid;
            tcdm_r_data_o[64*p +: 64]   = rsp[p].r_data;
            tcdm_r_id_o[ID_W*p +: ID_W] = rsp[p].r_id[ID_W-1:0];
            unused_id_bits = unused_id_bits ^ (^req[p].id) ^ (^rsp[p].r_id);
        end
    end

endmodule

// File: tb/tb_softex_tcdm_responder.sv
// Directed bench for softex_tcdm_responder: per-cycle reference model plus literal spot checks.
module tb_softex_tcdm_responder;

    localparam int          MP      = 4;
    localparam int          N_WORDS = 1024;
    localparam int          LATENCY = 1;
    localparam int          ID_W    = 8;
    localparam logic [31:0] BASE    = 32'h1000_0000;
    localparam logic        RD      = 1'b1;
    localparam logic        WR      = 1'b0;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic [MP-1:0]     tcdm_req_i, tcdm_gnt_o, tcdm_wen_i, tcdm_r_ready_i, tcdm_r_valid_o;
    logic [MP*32-1:0]  tcdm_add_i;
    logic [MP*8-1:0]   tcdm_be_i;
    logic [MP*64-1:0]  tcdm_data_i, tcdm_r_data_o;
    logic [MP*ID_W-1:0] tcdm_id_i, tcdm_r_id_o;
    logic              err_o;

    always #5 clk_i = ~clk_i;

    softex_tcdm_responder #(
        .MP(MP), .N_WORDS(N_WORDS), .LATENCY(LATENCY), .ID_W(ID_W), .BASE_ADDR(BASE)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .tcdm_req_i     (tcdm_req_i),
        .tcdm_gnt_o     (tcdm_gnt_o),
        .tcdm_add_i     (tcdm_add_i),
        .tcdm_wen_i     (tcdm_wen_i),
        .tcdm_be_i      (tcdm_be_i),
        .tcdm_data_i    (tcdm_data_i),
        .tcdm_id_i      (tcdm_id_i),
        .tcdm_r_ready_i (tcdm_r_ready_i),
        .tcdm_r_data_o  (tcdm_r_data_o),
        .tcdm_r_valid_o (tcdm_r_valid_o),
        .tcdm_r_id_o    (tcdm_r_id_o),
        .err_o          (err_o)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [63:0] data;
        logic        known;
        logic [7:0]  id;
        int          due;
    } exp_t;

    exp_t        q [MP][$];
    logic [63:0] mem_m [int];
    logic        err_m = 1'b0;
    int          cyc = 0;
    logic [MP-1:0] m_vis, m_elig, m_gnt, m_oor, m_set_err;
    logic [31:0] m_off;
    int          m_word [MP];
    int          m_bank [MP];
    exp_t        m_e;

    always @(negedge clk_i) begin
        if (!rst_ni) begin
            chk("reset_gnt", 64'(tcdm_gnt_o), 64'h0);
            chk("reset_rvalid", 64'(tcdm_r_valid_o), 64'h0);
            chk("reset_err", 64'(err_o), 64'h0);
            for (int p = 0; p < MP; p++) begin
                chk($sformatf("reset_rdata%0d", p), tcdm_r_data_o[64*p +: 64], 64'h0);
                chk($sformatf("reset_rid%0d", p), 64'(tcdm_r_id_o[8*p +: 8]), 64'h0);
                q[p].delete();
            end
            err_m = 1'b0;
        end else begin
            for (int p = 0; p < MP; p++) begin
                m_off     = tcdm_add_i[32*p +: 32] - BASE;
                m_oor[p]  = m_off >= 32'(8 * N_WORDS);
                m_word[p] = int'(m_off >> 3);
                m_bank[p] = m_word[p] % MP;
                m_vis[p]  = (q[p].size() > 0) && (q[p][0].due <= cyc);
                m_elig[p] = tcdm_req_i[p] && !(m_vis[p] && !tcdm_r_ready_i[p]);
            end
            for (int p = 0; p < MP; p++) begin
                m_gnt[p] = m_elig[p];
                for (int k = 0; k < p; k++) begin
                    if (m_elig[k] && !m_oor[k] && !m_oor[p] && m_bank[k] == m_bank[p]) m_gnt[p] = 1'b0;
                end
            end
            chk("gnt", 64'(tcdm_gnt_o), 64'(m_gnt));
            chk("err", 64'(err_o), 64'(err_m));
            for (int p = 0; p < MP; p++) begin
                chk($sformatf("rvalid%0d", p), 64'(tcdm_r_valid_o[p]), 64'(m_vis[p]));
                if (m_vis[p] && tcdm_r_valid_o[p]) begin
                    chk($sformatf("rid%0d", p), 64'(tcdm_r_id_o[8*p +: 8]), 64'(q[p][0].id));
                    if (q[p][0].known) chk($sformatf("rdata%0d", p), tcdm_r_data_o[64*p +: 64], q[p][0].data);
                end
            end
            // Advance model: retire or freeze responses, then serve grants (reads see pre-write data).
            m_set_err = m_gnt & m_oor;
            for (int p = 0; p < MP; p++) begin
                if (m_vis[p] && tcdm_r_ready_i[p]) begin
                    void'(q[p].pop_front());
                end else if (m_vis[p]) begin
                    for (int i = 0; i < q[p].size(); i++) begin
                        m_e = q[p][i];
                        m_e.due = m_e.due + 1;
                        q[p][i] = m_e;
                    end
                end
                if (m_gnt[p] && tcdm_wen_i[p]) begin
                    m_e.id    = tcdm_id_i[8*p +: 8];
                    m_e.due   = cyc + LATENCY;
                    m_e.known = m_oor[p] || mem_m.exists(m_word[p]);
                    m_e.data  = m_oor[p] ? 64'hDEAD_BEEF_DEAD_BEEF :
                                (mem_m.exists(m_word[p]) ? mem_m[m_word[p]] : 64'h0);
                    q[p].push_back(m_e);
                end
            end
            for (int p = 0; p < MP; p++) begin
                if (m_gnt[p] && !tcdm_wen_i[p] && !m_oor[p] &&
                    (mem_m.exists(m_word[p]) || tcdm_be_i[8*p +: 8] == 8'hFF)) begin
                    m_e.data = mem_m.exists(m_word[p]) ? mem_m[m_word[p]] : 64'h0;
                    for (int b = 0; b < 8; b++) begin
                        if (tcdm_be_i[8*p + b]) m_e.data[8*b +: 8] = tcdm_data_i[64*p + 8*b +: 8];
                    end
                    mem_m[m_word[p]] = m_e.data;
                end
            end
            if (|m_set_err) err_m = 1'b1;
        end
        cyc++;
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_port(input int p, input logic [31:0] add, input logic wen,
                            input logic [7:0] be, input logic [63:0] data, input logic [7:0] id);
        tcdm_req_i[p]           = 1'b1;
        tcdm_add_i[32*p +: 32]  = add;
        tcdm_wen_i[p]           = wen;
        tcdm_be_i[8*p +: 8]     = be;
        tcdm_data_i[64*p +: 64] = data;
        tcdm_id_i[8*p +: 8]     = id;
    endtask

    task automatic idle();
        tcdm_req_i = '0;
    endtask

    localparam logic [63:0] D0 = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] D1 = 64'h1111_2222_3333_4444;
    localparam logic [63:0] D2 = 64'h5555_6666_7777_8888;
    localparam logic [63:0] D3 = 64'h9999_AAAA_BBBB_CCCC;
    localparam logic [63:0] DN = 64'hFEED_FACE_CAFE_F00D;

    logic [31:0] bp_add [4];
    logic [63:0] bp_dat [4];
    int issued, got;

    initial begin
        tcdm_req_i = '0; tcdm_add_i = '0; tcdm_wen_i = '1; tcdm_be_i = '0;
        tcdm_data_i = '0; tcdm_id_i = '0; tcdm_r_ready_i = '1;
        set_port(0, BASE, WR, 8'hFF, 64'h1, 8'h0);
        step(); #2 chk("lit_gnt_in_reset", 64'(tcdm_gnt_o), 64'h0);
        step(); rst_ni = 1'b1; idle();

        // write then read back word 0
        step(); set_port(0, BASE, WR, 8'hFF, D0, 8'h00);
        #2 chk("lit_wr_gnt", 64'(tcdm_gnt_o), 64'h1);
        step(); set_port(0, BASE, RD, 8'h00, 64'h0, 8'h5A);
        #2 chk("lit_rd_gnt", 64'(tcdm_gnt_o), 64'h1);
        step(); idle();
        #2 chk("lit_rd_valid", 64'(tcdm_r_valid_o[0]), 64'h1);
        chk("lit_rd_data", tcdm_r_data_o[63:0], D0);
        chk("lit_rd_id", 64'(tcdm_r_id_o[7:0]), 64'h5A);

        // wide access on distinct banks
        step(); set_port(1, BASE + 8, WR, 8'hFF, D1, 0); set_port(2, BASE + 16, WR, 8'hFF, D2, 0);
        set_port(3, BASE + 24, WR, 8'hFF, D3, 0);
        #2 chk("lit_wide_wr_gnt", 64'(tcdm_gnt_o), 64'hE);
        step();
        for (int p = 0; p < MP; p++) set_port(p, BASE + 32'(8 * p), RD, 0, 0, 8'(8'h10 + p));
        #2 chk("lit_wide_rd_gnt", 64'(tcdm_gnt_o), 64'hF);
        step(); idle();
        #2 chk("lit_wide_valid", 64'(tcdm_r_valid_o), 64'hF);
        chk("lit_wide_data2", tcdm_r_data_o[191:128], D2);
        chk("lit_wide_data3", tcdm_r_data_o[255:192], D3);

        // bank conflict: port0 wins, port2 retries
        step(); set_port(0, BASE, RD, 0, 0, 8'h20); set_port(2, BASE + 32, RD, 0, 0, 8'h22);
        #2 chk("lit_conflict_gnt", 64'(tcdm_gnt_o), 64'h1);
        step(); tcdm_req_i[0] = 1'b0;
        #2 chk("lit_conflict_retry", 64'(tcdm_gnt_o), 64'h4);
        step(); idle();

        // read wins over later-granted write to the same word
        step(); set_port(0, BASE + 8, RD, 0, 0, 8'h30); set_port(1, BASE + 8, WR, 8'hFF, DN, 0);
        #2 chk("lit_raw_gnt", 64'(tcdm_gnt_o), 64'h1);
        step(); tcdm_req_i[0] = 1'b0;
        #2 chk("lit_raw_wr_gnt", 64'(tcdm_gnt_o), 64'h2);
        chk("lit_raw_old_data", tcdm_r_data_o[63:0], D1);

        // simultaneous write and read on different banks, then byte enables
        step(); idle(); set_port(0, BASE + 40, WR, 8'hFF, 64'h0, 0); set_port(3, BASE + 16, RD, 0, 0, 8'h3C);
        #2 chk("lit_rw_gnt", 64'(tcdm_gnt_o), 64'h9);
        step(); idle(); set_port(0, BASE + 40, WR, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        #2 chk("lit_rw_rdata3", tcdm_r_data_o[255:192], D2);
        step(); set_port(0, BASE + 40, RD, 0, 0, 8'h40);
        step(); idle();
        #2 chk("lit_be_data", tcdm_r_data_o[63:0], 64'h0000_0000_FFFF_FFFF);

        // backpressure stream on port1 (all bank 1)
        step(); set_port(1, BASE + 72, WR, 8'hFF, 64'h9, 0);
        step(); set_port(1, BASE + 104, WR, 8'hFF, 64'hD, 0);
        bp_add = '{BASE + 8, BASE + 40, BASE + 72, BASE + 104};
        bp_dat = '{DN, 64'h0000_0000_FFFF_FFFF, 64'h9, 64'hD};
        issued = 0; got = 0;
        for (int c = 0; c < 40 && got < 4; c++) begin
            step();
            tcdm_r_ready_i[1] = !(c >= 2 && c < 5);
            if (issued < 4) set_port(1, bp_add[issued], RD, 0, 0, 8'(8'h60 + issued));
            else tcdm_req_i[1] = 1'b0;
            #1;
            if (tcdm_r_valid_o[1] && !tcdm_r_ready_i[1] && tcdm_req_i[1])
                chk("lit_bp_no_gnt", 64'(tcdm_gnt_o[1]), 64'h0);
            if (tcdm_r_valid_o[1] && tcdm_r_ready_i[1]) begin
                chk($sformatf("lit_bp_data%0d", got), tcdm_r_data_o[127:64], bp_dat[got]);
                chk($sformatf("lit_bp_id%0d", got), 64'(tcdm_r_id_o[15:8]), 64'(8'h60 + got));
                got++;
            end
            if (tcdm_gnt_o[1]) issued++;
        end
        chk("lit_bp_count", 64'(got), 64'd4);
        step(); idle(); tcdm_r_ready_i = '1;

        // out-of-range read and write
        step(); set_port(3, BASE - 8, RD, 0, 0, 8'h33);
        #2 chk("lit_oor_gnt", 64'(tcdm_gnt_o), 64'h8);
        chk("lit_oor_err_before", 64'(err_o), 64'h0);
        step(); idle();
        #2 chk("lit_oor_data", tcdm_r_data_o[255:192], 64'hDEAD_BEEF_DEAD_BEEF);
        chk("lit_oor_err", 64'(err_o), 64'h1);
        step(); set_port(0, BASE + 32'(8 * N_WORDS), WR, 8'hFF, 64'h1, 0);
        #2 chk("lit_oor_wr_gnt", 64'(tcdm_gnt_o), 64'h1);
        step(); idle(); set_port(0, BASE, RD, 0, 0, 8'h70); tcdm_r_ready_i[0] = 1'b0;
        step(); idle();
        #2 chk("lit_held_valid", 64'(tcdm_r_valid_o[0]), 64'h1);
        chk("lit_err_sticky", 64'(err_o), 64'h1);
        step(); rst_ni = 1'b0;
        #2 chk("lit_rst_rvalid", 64'(tcdm_r_valid_o), 64'h0);
        chk("lit_rst_err", 64'(err_o), 64'h0);
        step(); rst_ni = 1'b1; tcdm_r_ready_i = '1;
        step(); set_port(0, BASE, RD, 0, 0, 8'h71);
        step(); idle();
        #2 chk("lit_mem_kept", tcdm_r_data_o[63:0], D0);
        step(); step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/softex_tcdm_responder.md
Name: softex_tcdm_responder

Overview:
- Multi-port TCDM slave model and memory that terminates the MP parallel 64-bit TCDM master ports driven by the SoftEx accelerator wrapper.
- Port p of a wide access carries address base+8*p.
- Banked, word-interleaved storage with fixed read latency, per-port grant arbitration on bank conflicts, and r_ready backpressure.
- Used in the SoftEx testbench and as the accelerator-local scratch memory in standalone FPGA builds.

Parameters:
- MP, 4, number of 64-bit ports and memory banks (power of 2, >=1)
- N_WORDS, 1024, total 64-bit words (multiple of MP)
- LATENCY, 1, grant-to-r_valid cycles for reads (1..4)
- ID_W, 8, transaction id width
- BASE_ADDR, 32'h1000_0000, byte address of word 0

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- tcdm_req_i  in  MP  request per port
- tcdm_gnt_o  out  MP  grant per port (combinational)
- tcdm_add_i  in  MPx32  byte address
- tcdm_wen_i  in  MP  1=read, 0=write
- tcdm_be_i  in  MPx8  byte enables (writes)
- tcdm_data_i  in  MPx64  write data
- tcdm_id_i  in  MPxID_W  request id
- tcdm_r_ready_i  in  MP  response accept
- tcdm_r_data_o  out  MPx64  read data
- tcdm_r_valid_o  out  MP  read response valid
- tcdm_r_id_o  out  MPxID_W  echoed id
- err_o  out  1  sticky out-of-range access flag

Behaviour:
- Reset:
  - r_valid_o=0, r_data_o=0, r_id_o=0, err_o=0.
  - Pipelines are flushed.
  - gnt_o is forced 0 while rst_ni is low.
  - Memory contents are not reset.
  - Reset mid-transaction drops all in-flight responses.
- Address decode:
  - off = add - BASE_ADDR; word = off[31:3]; bank = word mod MP; row = word / MP.
  - add[2:0] is ignored.
  - Out of range when off >= 8*N_WORDS (unsigned, so add < BASE_ADDR also counts).
- Arbitration, per cycle and combinational:
  - gnt_o[p] = req[p] & !stall[p] & (no lower-index port q has req[q] & !stall[q] to the same bank).
  - Lowest index wins; a losing port retries next cycle.
  - Out-of-range requests never conflict.
- Write on grant:
  - Bytes with be=1 are updated at the clock edge.
  - No response is produced.
  - Out-of-range writes are dropped and set err_o.
- Read on grant:
  - Enters a per-port LATENCY-stage shift pipeline carrying {valid, row, bank, id, oor}.
  - Data is read from the array so that r_valid_o rises exactly LATENCY cycles after the grant cycle.
  - Read-after-write to the same word in the grant cycle returns old data.
  - A write granted in a cycle after the read's grant is not reflected.
  - Out-of-range reads return 64'hDEAD_BEEF_DEAD_BEEF and set err_o.
- Backpressure, per port:
  - Output register holds while r_valid_o & !r_ready_i.
  - While held, the port's pipeline freezes and stall[p]=1, so no new grant.
  - When r_ready_i=1 the pipeline advances; back-to-back reads sustain 1/cycle.
- Simultaneous read and write on different banks in the same cycle are both served.
- Same bank, two ports: only the winner is served.
- err_o clears only on reset.

Optional Feature:
- Macro SOFTEX_TCDM_STALL_EN.
- When defined:
  - Each port has a 16-bit Fibonacci LFSR (taps 16,14,13,11), seeded 16'hACE1 ^ p at reset, advancing every cycle.
  - stall[p] is additionally asserted when lfsr[1:0]==2'b11, giving ~25% random grant denial to stress the master's all-ports-granted logic.
- When undefined: no LFSR; stall derives only from backpressure.

Decomposition:
- softex_tcdm_pkg holds:
  - typedef tcdm_req_t {add, wen, be, data, id}
  - typedef tcdm_rsp_t {r_data, r_id, r_valid}
  - localparam OOR_PATTERN = 64'hDEAD_BEEF_DEAD_BEEF
  - function bank_of
- One sub-module, softex_tcdm_bank: single-port byte-enabled synchronous SRAM (N_WORDS/MP rows x 64).
  - Instantiated MP times.
  - Crossbar select is done in the top.

Test Plan:
- Write word: port0 add=BASE, be=8'hFF, data=64'h0123_4567_89AB_CDEF, then read with id=8'h5A → gnt same cycle; r_valid 1 cycle later with that data and r_id=8'h5A.
- Wide access: all 4 ports req with addresses BASE+0/8/16/24 → all gnt=1 in one cycle (distinct banks); reads return the 4 written words simultaneously.
- Bank conflict: port0 add=BASE, port2 add=BASE+32 (both bank 0) → gnt=4'b0001, then port2 granted next cycle.
- Byte enable: write 64'hFFFF… with be=8'h0F over 0 → read returns 64'h0000_0000_FFFF_FFFF.
- Backpressure: port1 streams 4 reads with r_ready=0 for 3 cycles → gnt[1] drops while held; all 4 responses are delivered in order with no loss or duplication.
- Out of range: read add=BASE-8 → r_data=64'hDEAD_BEEF_DEAD_BEEF, err_o=1 until rst_ni is pulsed low mid-stream, which clears r_valid and err_o.
